// File: rtl/blockmem_pkg.sv
// Shared types and constants for the block-RAM read stream engine.
package blockmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    FIN
  } rd_state_t;

  localparam int unsigned C_RD_BUF_DEPTH = 2;

endpackage

// File: rtl/blockmem_rd_stream_if.sv
// Valid/ready stream with last marker.
interface blockmem_rd_stream_if #(
  parameter int unsigned G_DATAWIDTH = 32
);

  logic [G_DATAWIDTH-1:0] m_tdata;
  logic                   m_tvalid;
  logic                   m_tready;
  logic                   m_tlast;

  modport master (
    output m_tdata,
    output m_tvalid,
    output m_tlast,
    input  m_tready
  );

  modport slave (
    input  m_tdata,
    input  m_tvalid,
    input  m_tlast,
    output m_tready
  );

endinterface

// File: rtl/blockmem_skid2.sv
// Two-entry FIFO holding RAM read data until the stream consumer takes it.
// Entry 0 is always the head; a pop shifts entry 1 down.
module blockmem_skid2
  import blockmem_pkg::*;
#(
  parameter int unsigned G_DATAWIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [G_DATAWIDTH-1:0] push_data_i,
  output logic [G_DATAWIDTH-1:0] data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [1:0]             count_o
);

  logic [G_DATAWIDTH-1:0] ent0_q, ent0_d;
  logic [G_DATAWIDTH-1:0] ent1_q, ent1_d;
  logic [1:0]             cnt_q, cnt_d;
  logic                   pop;

  assign valid_o = (cnt_q != 2'd0);
  assign data_o  = ent0_q;
  assign count_o = cnt_q;
  assign pop     = valid_o & ready_i;

  // Next-state for entries and occupancy; a simultaneous push and pop keeps order.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      cnt_d = '0;
    end else begin
      case ({push_i, pop})
        2'b10: begin
          if (cnt_q == 2'd0) ent0_d = push_data_i;
          else               ent1_d = push_data_i;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          ent0_d = ent1_q;
          cnt_d  = cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'(C_RD_BUF_DEPTH)) begin
            ent0_d = ent1_q;
            ent1_d = push_data_i;
          end else begin
            ent0_d = push_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= '0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/blockmem_rd_stream.sv
// Read-side engine for the two-port block RAM: sweeps len words from start_addr
// through the registered read port and streams them out with last.
module blockmem_rd_stream
  import blockmem_pkg::*;
#(
  parameter int unsigned G_DATAWIDTH = 32,
  parameter int unsigned G_MEMDEPTH  = 1024,
  parameter int unsigned G_ADDRWIDTH = $clog2(G_MEMDEPTH),
  parameter int unsigned G_LENWIDTH  = G_ADDRWIDTH + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [G_ADDRWIDTH-1:0] start_addr,
  input  logic [G_LENWIDTH-1:0]  len,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic                   enb,
  output logic [G_ADDRWIDTH-1:0] addrb,
  input  logic [G_DATAWIDTH-1:0] doutb,
  blockmem_rd_stream_if.master   m_axis
);

  localparam logic [G_LENWIDTH-1:0]  L_ONE  = G_LENWIDTH'(1);
  localparam logic [G_ADDRWIDTH-1:0] A_LAST = G_ADDRWIDTH'(G_MEMDEPTH - 1);

  rd_state_t              state_q;
  logic [G_LENWIDTH-1:0]  len_q;
  logic [G_LENWIDTH-1:0]  issue_q;
  logic [G_LENWIDTH-1:0]  beat_q;
  logic [G_ADDRWIDTH-1:0] addr_q;
  logic                   pend_q;
  logic                   busy_q;
  logic                   done_q;

  logic                   buf_valid;
  logic [G_DATAWIDTH-1:0] buf_data;
  logic [1:0]             occ;
  logic                   pop;
  logic                   active;
  logic                   push;
  logic                   flush;
  logic [2:0]             credit;
  logic                   last_issue;
  logic                   last_beat;

  assign active = (state_q == READ) || (state_q == DRAIN);
  assign pop    = buf_valid & m_axis.m_tready;
  // Credit counts the slot freed by a pop this same cycle, which is what lets
  // reads issue back-to-back while the consumer keeps up.
  assign credit = 3'(occ) + 3'(pend_q) - 3'(pop);
  assign enb    = (state_q == READ) && !abort && (issue_q < len_q) &&
                  (credit < 3'(C_RD_BUF_DEPTH));
  assign push   = pend_q && active && !abort;
  assign flush  = abort && active;

  assign last_issue = (issue_q == len_q - L_ONE);
  assign last_beat  = pop && (beat_q == len_q - L_ONE);

  assign addrb           = addr_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign m_axis.m_tvalid = buf_valid;
  assign m_axis.m_tdata  = buf_data;
  assign m_axis.m_tlast  = buf_valid && (beat_q == len_q - L_ONE);

  blockmem_skid2 #(
    .G_DATAWIDTH(G_DATAWIDTH)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .push_i      (push),
    .push_data_i (doutb),
    .data_o      (buf_data),
    .valid_o     (buf_valid),
    .ready_i     (m_axis.m_tready),
    .count_o     (occ)
  );

  // Transfer control: state, address/issue/beat counters and registered status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      issue_q <= '0;
      beat_q  <= '0;
      addr_q  <= '0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      pend_q <= enb;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            len_q   <= len;
            addr_q  <= start_addr;
            issue_q <= '0;
            beat_q  <= '0;
            busy_q  <= 1'b1;
            if (len == '0) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              state_q <= READ;
            end
          end
        end
        READ: begin
          if (abort) begin
            state_q <= FIN;
            done_q  <= 1'b1;
          end else begin
            if (enb) begin
              addr_q  <= (addr_q == A_LAST) ? '0 : addr_q + G_ADDRWIDTH'(1);
              issue_q <= issue_q + L_ONE;
              if (last_issue) state_q <= DRAIN;
            end
            if (pop) beat_q <= beat_q + L_ONE;
          end
        end
        DRAIN: begin
          if (abort) begin
            state_q <= FIN;
            done_q  <= 1'b1;
          end else begin
            if (pop) beat_q <= beat_q + L_ONE;
            if (last_beat) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end
          end
        end
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blockmem_rd_stream.sv
module tb_blockmem_rd_stream;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned AW    = 10;
  localparam int unsigned LW    = 11;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic          busy;
  logic          done;
  logic          enb;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] addrb;
  logic [LW-1:0] len;
  logic [DW-1:0] doutb = '0;
  logic [DW-1:0] mem [DEPTH];

  blockmem_rd_stream_if #(.G_DATAWIDTH(DW)) s_if ();

  blockmem_rd_stream #(
    .G_DATAWIDTH(DW),
    .G_MEMDEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .len        (len),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .enb        (enb),
    .addrb      (addrb),
    .doutb      (doutb),
    .m_axis     (s_if)
  );

  exp_t        exp_q[$];
  int unsigned vectors      = 0;
  int unsigned miscompares  = 0;
  int unsigned cyc          = 0;
  int unsigned beats        = 0;
  int unsigned enb_cnt      = 0;
  int unsigned enb_at0      = 0;
  int unsigned valid_cnt    = 0;
  int unsigned busy_cnt     = 0;
  int unsigned done_cnt     = 0;
  int unsigned done_cyc     = 0;
  int unsigned enb_rise_cyc = 0;
  int unsigned beat_cyc [2048];
  logic        enb_prev;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // RAM with registered read port: mem[i] = i + 0x100, output held while enb=0.
  initial for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 256);
  always @(posedge clk) if (enb) doutb <= mem[addrb];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Monitor: pops the scoreboard on every handshake and checks the presented word.
  initial begin
    enb_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        enb_prev = 1'b0;
      end else begin
        if (enb) begin
          enb_cnt++;
          if (addrb == '0) enb_at0++;
          if (!enb_prev) enb_rise_cyc = cyc;
        end
        enb_prev = enb;
        if (s_if.m_tvalid) valid_cnt++;
        if (busy) busy_cnt++;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (s_if.m_tvalid) begin
          if (exp_q.size() != 0) begin
            chk("tdata", s_if.m_tdata, exp_q[0].data);
            chk("tlast", 32'(s_if.m_tlast), 32'(exp_q[0].last));
          end
          if (s_if.m_tready) begin
            if (exp_q.size() == 0) begin
              vectors++;
              miscompares++;
              $display("FAIL unexpected_beat: got data 0x%0h, required no beat (cycle %0d)",
                       s_if.m_tdata, cyc);
            end else begin
              void'(exp_q.pop_front());
            end
            beat_cyc[beats % 2048] = cyc;
            beats++;
          end
        end
      end
    end
  end

  task automatic run_xfer(input int unsigned a, input int unsigned n, input bit rnd,
                          input int unsigned ab, input bit abort_with_start, input bit restart);
    int unsigned base, eb, vb, bb, db, s, nexp, ea;
    bit aborted, fin;
    base = beats; eb = enb_cnt; vb = valid_cnt; bb = busy_cnt; db = done_cnt; ea = 0;
    nexp = (ab != 0) ? ab : n;
    for (int unsigned i = 0; i < nexp; i++)
      exp_q.push_back('{data: DW'(((a + i) % DEPTH) + 256), last: (ab == 0 && i == n - 1)});
    start_addr = AW'(a);
    len        = LW'(n);
    start      = 1'b1;
    abort      = abort_with_start;
    s_if.m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    aborted = 1'b0;
    fin = 1'b0;
    for (int c = 0; c < 4000 && !fin; c++) begin
      if (done_cnt != db) begin
        fin = 1'b1;
      end else begin
        if (restart && c == 2) begin
          start      = 1'b1;
          start_addr = AW'(a + 50);
          len        = LW'(3);
        end else begin
          start = 1'b0;
        end
        if (ab != 0 && !aborted && (beats - base) == ab) begin
          abort = 1'b1;
          s_if.m_tready = 1'b0;
          aborted = 1'b1;
          ea = enb_cnt;
        end else begin
          abort = 1'b0;
          s_if.m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    if (!fin) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no done pulse, required one (start_addr %0d len %0d)", a, n);
    end
    chk("done_pulses", done_cnt - db, 1);
    chk("beat_count", beats - base, nexp);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("busy_after_done", 32'(busy), 0);
    if (ab != 0) chk("enb_after_abort", enb_cnt - ea, 0);
    if (n == 0) begin
      chk("len0_enb", enb_cnt - eb, 0);
      chk("len0_valid", valid_cnt - vb, 0);
      chk("len0_busy_cycles", busy_cnt - bb, 1);
      chk("len0_done_cycle", done_cyc, s + 1);
    end else if (ab == 0) begin
      chk("done_after_last", done_cyc, beat_cyc[(base + n - 1) % 2048] + 1);
      if (!rnd) begin
        chk("throughput", beat_cyc[(base + n - 1) % 2048] - beat_cyc[base % 2048], n - 1);
        chk("first_enb_latency", enb_rise_cyc, s + 1);
      end
    end
    exp_q.delete();
  endtask

  initial begin
    int unsigned z0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; start_addr = '0; len = '0;
    s_if.m_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_enb", 32'(enb), 0);
    chk("rst_addrb", 32'(addrb), 0);
    chk("rst_tvalid", 32'(s_if.m_tvalid), 0);
    chk("rst_tlast", 32'(s_if.m_tlast), 0);
    chk("rst_tdata", s_if.m_tdata, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_xfer(4, 8, 1'b0, 0, 1'b0, 1'b0);
    z0 = enb_at0;
    run_xfer(1022, 4, 1'b0, 0, 1'b0, 1'b0);
    chk("addrb_wrap", enb_at0 - z0, 1);
    run_xfer($urandom_range(0, DEPTH - 1), 6, 1'b1, 0, 1'b0, 1'b0);
    run_xfer(7, 0, 1'b0, 0, 1'b0, 1'b0);
    run_xfer(16, 16, 1'b0, 3, 1'b0, 1'b0);
    run_xfer(100, 5, 1'b0, 0, 1'b0, 1'b0);

    // Reset in the middle of a stalled READ.
    s_if.m_tready = 1'b0;
    start_addr = AW'(200);
    len = LW'(16);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("midread_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_enb", 32'(enb), 0);
    chk("async_rst_addrb", 32'(addrb), 0);
    chk("async_rst_tvalid", 32'(s_if.m_tvalid), 0);
    chk("async_rst_tdata", s_if.m_tdata, 0);
    chk("async_rst_tlast", 32'(s_if.m_tlast), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_xfer(300, 6, 1'b1, 0, 1'b1, 1'b1);

    for (int t = 0; t < 6; t++) begin
      int unsigned a, n, ab;
      bit r;
      a  = $urandom_range(0, DEPTH - 1);
      n  = $urandom_range(1, 24);
      r  = 1'($urandom_range(0, 1));
      ab = (n >= 2 && $urandom_range(0, 3) == 0) ? $urandom_range(1, n - 1) : 0;
      run_xfer(a, n, r, ab, 1'b0, 1'b0);
    end

    run_xfer(517, DEPTH, 1'b0, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
